// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_LOGIEX  = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // alucontrol
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alusrcb
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // pcsrc
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // what the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2,
    AOP_LOGIC = 2'd3
  } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: aluop + funct/op -> alucontrol, flags unknown R-type funct.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  input  logic [5:0]  op,
  output logic [2:0]  alucontrol,
  output logic        bad_funct
);

  // unknown funct falls back to add so the datapath stays deterministic
  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      AOP_ADD:   alucontrol = ALU_ADD;
      AOP_SUB:   alucontrol = ALU_SUB;
      AOP_LOGIC: alucontrol = (op == OP_ORI) ? ALU_OR : ALU_AND;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with optional bne and andi/ori decode.
module mc_controller
  import mips_pkg::*;
#(
  parameter bit EN_BNE       = 1'b0,
  parameter bit EN_LOGIC_IMM = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  state_t state, next;
  aluop_t aluop;
  logic   bad_funct;
  logic   is_mem, is_branch, is_bne, is_logic, op_ok;
  logic   pcen_r, memwrite_r, irwrite_r, regwrite_r, illegal_r;

  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign is_bne    = EN_BNE && (op == OP_BNE);
  assign is_branch = (op == OP_BEQ) || is_bne;
  assign is_logic  = EN_LOGIC_IMM && ((op == OP_ANDI) || (op == OP_ORI));
  assign op_ok     = is_mem || is_branch || is_logic || (op == OP_RTYPE) ||
                     (op == OP_ADDI) || (op == OP_J);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .op         (op),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

  // state register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  // next-state: memory states stall on mem_ready, DECODE dispatches on op
  always_comb begin
    next = state;
    case (state)
      S_FETCH:   if (mem_ready) next = S_DECODE;
      S_DECODE: begin
        if (is_mem)                 next = S_MEMADR;
        else if (op == OP_RTYPE)    next = S_RTYPEEX;
        else if (is_branch)         next = S_BEQEX;
        else if (op == OP_ADDI)     next = S_ADDIEX;
        else if (is_logic)          next = S_LOGIEX;
        else if (op == OP_J)        next = S_JEX;
        else                        next = S_FETCH;
      end
      S_MEMADR:  next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) next = S_MEMWB;
      S_MEMWR:   if (mem_ready) next = S_FETCH;
      S_RTYPEEX: next = S_RTYPEWB;
      S_ADDIEX,
      S_LOGIEX:  next = S_IMMWB;
      default:   next = S_FETCH;
    endcase
  end

  // outputs: Moore, qualified only by mem_ready and zero
  always_comb begin
    pcen_r     = 1'b0;
    iord       = 1'b0;
    memwrite_r = 1'b0;
    irwrite_r  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_r = 1'b0;
    alusrca    = 1'b0;
    illegal_r  = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PCSRC_ALU;
    aluop      = AOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        irwrite_r = mem_ready;
        pcen_r    = mem_ready;
      end
      S_DECODE: begin
        alusrcb   = SRCB_IMMSH;
        illegal_r = !op_ok;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_r = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_r = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = AOP_FUNCT;
        illegal_r = bad_funct;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_r = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen_r  = is_bne ? !zero : zero;
      end
      S_ADDIEX: alusrcb = SRCB_IMM;
      S_LOGIEX: begin
        alusrcb = SRCB_IMM;
        aluop   = AOP_LOGIC;
      end
      S_IMMWB: regwrite_r = 1'b1;
      S_JEX: begin
        pcsrc  = PCSRC_JUMP;
        pcen_r = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes drop the instant reset asserts, without waiting for a clock
  assign pcen     = pcen_r     & reset_n;
  assign irwrite  = irwrite_r  & reset_n;
  assign regwrite = regwrite_r & reset_n;
  assign memwrite = memwrite_r & reset_n;
  assign illegal  = illegal_r  & reset_n;
  assign state_o  = state;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter EN_BNE, default 0; 1 = decode bne (op 000101) as a branch.
REQ-002 SHALL have parameter EN_LOGIC_IMM, default 0; 1 = decode andi (001100) and ori (001101).
REQ-003 SHALL have ports clk (input, 1 bit, single clock) and reset_n (input, 1 bit, asynchronous active-low reset); all state SHALL update on the rising edge of clk.
REQ-004 SHALL have the following data inputs:
  - op, input, 6 bits: instruction opcode from the instruction register.
  - funct, input, 6 bits: R-type function field.
  - zero, input, 1 bit: ALU zero flag.
  - mem_ready, input, 1 bit: memory access completes this cycle.
REQ-005 SHALL have the following 1-bit outputs:
  - pcen: PC write enable.
  - iord: memory address select; 1 = ALUOut.
  - memwrite: memory write strobe.
  - irwrite: instruction register write enable.
  - regdst: 1 = destination is rd.
  - memtoreg: 1 = write-back data from memory.
  - regwrite: register-file write strobe.
  - alusrca: 1 = ALU A operand is register A.
  - illegal: 1-cycle pulse on an undecodable opcode.
REQ-006 SHALL have the following multi-bit outputs:
  - alusrcb, output, 2 bits: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
  - pcsrc, output, 2 bits: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
  - alucontrol, output, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt.
  - state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, LOGIEX, IMMWB, JEX; only mem_ready and zero qualify outputs.
REQ-008 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00; irwrite=pcen=mem_ready; it SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-009 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=add, and branch by op:
  - lw (100011) or sw (101011) -> MEMADR.
  - R-type (000000) -> RTYPEEX.
  - beq (000100), or bne when EN_BNE=1 -> BEQEX.
  - addi (001000) -> ADDIEX.
  - andi/ori when EN_LOGIC_IMM=1 -> LOGIEX.
  - j (000010) -> JEX.
  - any other op -> FETCH, with illegal=1 for that one cycle.
REQ-010 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=add, then go to MEMRD for lw and MEMWR for sw.
REQ-011 MEMRD SHALL drive iord=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-012 MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1, then go to FETCH.
REQ-013 MEMWR SHALL drive iord=1 and memwrite=1 every cycle until mem_ready=1, then go to FETCH.
REQ-014 RTYPEEX SHALL drive alusrca=1, alusrcb=00, with alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; unknown funct SHALL give alucontrol=010 and illegal=1.
REQ-015 RTYPEWB SHALL drive regdst=1, memtoreg=0, regwrite=1, then go to FETCH.
REQ-016 BEQEX SHALL drive alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01; pcen = zero for beq and ~zero for bne; it SHALL then go to FETCH.
REQ-017 ADDIEX SHALL use alucontrol=add with alusrcb=10; LOGIEX SHALL use alucontrol and/or per op with alusrcb=10; both SHALL go to IMMWB.
REQ-018 IMMWB SHALL drive regdst=0, memtoreg=0, regwrite=1, then go to FETCH.
REQ-019 JEX SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-020 Every output not listed for a state SHALL be 0.
REQ-021 Ideal-memory latency in cycles (mem_ready held at 1):
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-022 At most one of regwrite and memwrite SHALL be 1 in any cycle, and irwrite SHALL be 1 only in FETCH.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state FETCH and force pcen, irwrite, regwrite, memwrite and illegal to 0 regardless of mem_ready; other outputs SHALL take their FETCH values.
REQ-024 Assertion of reset mid-instruction, including during a MEMWR wait, SHALL drop memwrite in the same cycle, and the first FETCH SHALL follow the first rising clk edge after reset_n returns to 1.

Structure
REQ-025 Package mips_pkg SHALL hold the state enum, the opcode and funct constants, the alucontrol/alusrcb/pcsrc encodings and the aluop type.
REQ-026 Sub-module mc_aludec SHALL map aluop, funct and op to alucontrol and its illegal-funct flag, combinationally.

Verification
REQ-027 lw (op 100011) with mem_ready=1 throughout: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-028 mem_ready=0 for 2 cycles in FETCH: irwrite=pcen=0 in those cycles; both are 1 in cycle 3; DECODE follows.
REQ-029 beq with zero=1 in BEQEX: pcen=1, pcsrc=01, alucontrol=110; repeated with zero=0: pcen=0.
REQ-030 bne (000101) with EN_BNE=0: illegal=1 in DECODE, then FETCH; with EN_BNE=1 and zero=0: pcen=1 in BEQEX.
REQ-031 sw with mem_ready=0 for 3 cycles in MEMWR, then reset_n=0 asynchronously: memwrite falls within the same cycle and state_o shows FETCH.
REQ-032 R-type with funct 101010: alucontrol=111 in RTYPEEX; funct 111111: illegal=1 and alucontrol=010.
